// File: rtl/adc_spi_top_if.sv
// SPI pad signals plus the tagged conversion-result bus of the ADC wing.
// master = the scanning SPI master, slave = ADC device / result consumer side.
interface adc_spi_top_if;
  logic        miso;
  logic        mosi;
  logic        sck;
  logic        ss;
  logic [11:0] data_o;
  logic [2:0]  chan_o;
  logic        valid_o;

  modport master (input miso, output mosi, sck, ss, data_o, chan_o, valid_o);
  modport slave  (output miso, input mosi, sck, ss, data_o, chan_o, valid_o);
endinterface

// File: rtl/adc_spi_top.sv
// Free-running SPI master scanning an 8-channel 12-bit ADC round-robin; each
// result leaves with its channel tag and a one-cycle valid strobe.
module adc_spi_top #(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8,
  parameter int NUM_CH  = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  adc_spi_top_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [2:0]  ADDR_LAST = 3'(NUM_CH - 1);

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [4:0]  half_r, half_s;
  logic [2:0]  addr_r, addr_s;
  logic [2:0]  prev_addr_r, prev_addr_s;
  logic        first_r, first_s;
  logic [11:0] rx_r, rx_s;
  logic        ss_r, ss_s;
  logic        sck_r, sck_s;
  logic        mosi_r, mosi_s;
  logic        valid_r, valid_s;
  logic [11:0] data_r, data_s;
  logic [2:0]  chan_r, chan_s;
  logic [15:0] tx_s;
  logic [3:0]  bit_idx_s;

  assign tx_s = {2'b00, addr_r, 11'b0};
  // Odd half 2k-1 ends with falling edge k, which presents frame bit 15-k.
  assign bit_idx_s = 4'd14 - half_r[4:1];

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    half_s      = half_r;
    addr_s      = addr_r;
    prev_addr_s = prev_addr_r;
    first_s     = first_r;
    rx_s        = rx_r;
    ss_s        = ss_r;
    sck_s       = sck_r;
    mosi_s      = mosi_r;
    valid_s     = 1'b0;
    data_s      = data_r;
    chan_s      = chan_r;
    case (state_r)
      IDLE: begin
        state_s = START;
        cnt_s   = 16'd0;
        ss_s    = 1'b0;
        sck_s   = 1'b1;
        mosi_s  = tx_s[15];
      end
      START: begin
        if (cnt_r == DIV_LAST) begin
          state_s = SHIFT;
          cnt_s   = 16'd0;
          half_s  = 5'd0;
          sck_s   = 1'b0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_r == DIV_LAST) begin
          cnt_s  = 16'd0;
          half_s = half_r + 5'd1;
          // Only the last 12 bits survive; the four leading zeros shift out.
          if (half_r[0] == 1'b0) begin
            sck_s = 1'b1;
            rx_s  = {rx_r[10:0], bus.miso};
          end else if (half_r == 5'd31) begin
            state_s = STOP;
          end else begin
            sck_s  = 1'b0;
            mosi_s = tx_s[bit_idx_s];
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      STOP: begin
        if (cnt_r == DIV_LAST) begin
          state_s     = GAP;
          cnt_s       = 16'd0;
          ss_s        = 1'b1;
          mosi_s      = 1'b0;
          first_s     = 1'b0;
          prev_addr_s = addr_r;
          addr_s      = (addr_r == ADDR_LAST) ? 3'd0 : addr_r + 3'd1;
          // The ADC answers for the address sent in the previous frame.
          if (!first_r) begin
            valid_s = 1'b1;
            data_s  = rx_r;
            chan_s  = prev_addr_r;
          end else begin
            valid_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = START;
          cnt_s   = 16'd0;
          ss_s    = 1'b0;
          mosi_s  = tx_s[15];
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        ss_s    = 1'b1;
        sck_s   = 1'b1;
        mosi_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      cnt_r       <= 16'd0;
      half_r      <= 5'd0;
      addr_r      <= 3'd0;
      prev_addr_r <= 3'd0;
      first_r     <= 1'b1;
      rx_r        <= 12'd0;
      ss_r        <= 1'b1;
      sck_r       <= 1'b1;
      mosi_r      <= 1'b0;
      valid_r     <= 1'b0;
      data_r      <= 12'd0;
      chan_r      <= 3'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      half_r      <= half_s;
      addr_r      <= addr_s;
      prev_addr_r <= prev_addr_s;
      first_r     <= first_s;
      rx_r        <= rx_s;
      ss_r        <= ss_s;
      sck_r       <= sck_s;
      mosi_r      <= mosi_s;
      valid_r     <= valid_s;
      data_r      <= data_s;
      chan_r      <= chan_s;
    end
  end

  assign bus.ss      = ss_r;
  assign bus.sck     = sck_r;
  assign bus.mosi    = mosi_r;
  assign bus.valid_o = valid_r;
  assign bus.data_o  = data_r;
  assign bus.chan_o  = chan_r;

endmodule

// File: tb/tb_adc_spi_top.sv
// Bench for adc_spi_top: ADC device model on the pads, frame monitor, table of
// expected frames, reset corner cases and a randomized scoreboard run.
module tb_adc_spi_top;
  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 8;
  localparam int NUM_CH  = 8;

  typedef struct {
    logic [15:0] mosi;
    int          nvalid;
    logic [2:0]  chan;
    logic [11:0] data;
  } vec_t;

  typedef struct {
    bit          ok;
    logic [15:0] mosi;
    int          lows;
    int          bad_runs;
    int          ss_low;
    int          gap;
    int          gap_sck_bad;
    int          nvalid;
    logic [11:0] data;
    logic [2:0]  chan;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int mode = 0;  // 0 table values, 1 miso stuck 1, 2 stuck 0, 3 random
  logic [11:0] chan_val [8];
  logic [14:0] exp_q [$];

  adc_spi_top_if bus ();

  adc_spi_top #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .NUM_CH(NUM_CH)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  // ADC device: DOUT changes on sck falls, DIN captured on rises; every
  // address received is converted and queued as the expected next result.
  initial begin : adc_model
    logic prev_ss, prev_sck, have;
    logic [15:0] word, din;
    logic [11:0] pending, val;
    int falls, rises;
    bus.miso = 1'b0;
    prev_ss = 1'b1; prev_sck = 1'b1; have = 1'b0;
    word = 16'h0; din = 16'h0; pending = 12'h0; val = 12'h0;
    falls = 0; rises = 0;
    forever begin
      @(bus.ss or bus.sck or rst);
      if (rst === 1'b1) begin
        have = 1'b0;
        rises = 0;
        exp_q.delete();
      end else if (prev_ss === 1'b1 && bus.ss === 1'b0) begin
        falls = 0; rises = 0; din = 16'h0;
        word = (mode == 1) ? 16'hFFFF : (have ? {4'h0, pending} : 16'hBAD5);
        bus.miso = word[15];
      end else if (prev_ss === 1'b0 && bus.ss === 1'b1) begin
        if (rises == 16) begin
          case (mode)
            1: val = 12'hFFF;
            2: val = 12'h000;
            3: val = 12'($urandom_range(4095, 0));
            default: val = chan_val[din[13:11]];
          endcase
          exp_q.push_back({din[13:11], val});
          pending = val;
          have = 1'b1;
        end else begin
          have = 1'b0;
        end
      end else if (bus.ss === 1'b0 && prev_sck === 1'b1 && bus.sck === 1'b0) begin
        falls++;
        if (falls >= 2 && falls <= 16) bus.miso = word[16 - falls];
      end else if (bus.ss === 1'b0 && prev_sck === 1'b0 && bus.sck === 1'b1) begin
        din = {din[14:0], bus.mosi};
        rises++;
      end
      prev_ss = bus.ss;
      prev_sck = bus.sck;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Observes one frame (from its first ss-low sample) and the gap after it.
  task automatic capture(output frame_t f);
    int budget;
    int run;
    logic prev_sck;
    f = '{default: 0};
    budget = 0;
    while (bus.ss !== 1'b0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (bus.ss !== 1'b0) return;
    f.ok = 1'b1;
    prev_sck = bus.sck;
    run = 0;
    while (bus.ss === 1'b0 && f.ss_low < 1000) begin
      f.ss_low++;
      if (bus.sck !== prev_sck) begin
        if (run != CLK_DIV) f.bad_runs++;
        if (bus.sck === 1'b1) f.mosi = {f.mosi[14:0], bus.mosi};
        else f.lows++;
        run = 0;
      end
      if (bus.valid_o === 1'b1) f.nvalid++;
      run++;
      prev_sck = bus.sck;
      @(negedge clk);
    end
    while (bus.ss === 1'b1 && f.gap < 100) begin
      f.gap++;
      if (bus.sck !== 1'b1) f.gap_sck_bad++;
      if (bus.valid_o === 1'b1) begin
        f.nvalid++;
        f.data = bus.data_o;
        f.chan = bus.chan_o;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input frame_t f, input string tag, input logic [15:0] mosi,
                             input int nvalid, input logic [2:0] chan, input logic [11:0] data);
    check({tag, "_started"}, 32'(f.ok), 32'd1);
    check({tag, "_sck_lows"}, f.lows, 16);
    check({tag, "_sck_runs"}, f.bad_runs, 0);
    check({tag, "_ss_low"}, f.ss_low, 34 * CLK_DIV);
    check({tag, "_gap"}, f.gap, GAP_CYC);
    check({tag, "_gap_sck"}, f.gap_sck_bad, 0);
    check({tag, "_mosi"}, {16'h0, f.mosi}, {16'h0, mosi});
    check({tag, "_nvalid"}, f.nvalid, nvalid);
    if (nvalid == 1) begin
      check({tag, "_chan"}, {29'h0, f.chan}, {29'h0, chan});
      check({tag, "_data"}, {20'h0, f.data}, {20'h0, data});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : main
    vec_t tbl [10];
    frame_t f;
    int n;
    bit bad;
    logic [14:0] e;
    logic [2:0] ea;

    chan_val = '{12'hA5C, 12'h137, 12'h2E4, 12'h0F1, 12'h8C6, 12'h55A, 12'hFFE, 12'h3B9};
    tbl[0] = '{16'h0000, 0, 3'd0, 12'h000};
    tbl[1] = '{16'h0800, 1, 3'd0, 12'hA5C};
    tbl[2] = '{16'h1000, 1, 3'd1, 12'h137};
    tbl[3] = '{16'h1800, 1, 3'd2, 12'h2E4};
    tbl[4] = '{16'h2000, 1, 3'd3, 12'h0F1};
    tbl[5] = '{16'h2800, 1, 3'd4, 12'h8C6};
    tbl[6] = '{16'h3000, 1, 3'd5, 12'h55A};
    tbl[7] = '{16'h3800, 1, 3'd6, 12'hFFE};
    tbl[8] = '{16'h0000, 1, 3'd7, 12'h3B9};
    tbl[9] = '{16'h0800, 1, 3'd0, 12'hA5C};

    // Power-on reset held 100 ns.
    rst = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.ss !== 1'b1 || bus.sck !== 1'b1 || bus.mosi !== 1'b0 || bus.valid_o !== 1'b0 ||
          bus.data_o !== 12'h000 || bus.chan_o !== 3'd0) bad = 1'b1;
    end
    check("reset_hold", 32'(bad), 32'd0);
    rst = 1'b0;
    n = 0;
    while (bus.ss !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ss_fall_within_2", 32'(n >= 1 && n <= 2), 32'd1);

    for (int i = 0; i < 10; i++) begin
      capture(f);
      check_frame(f, $sformatf("tbl%0d", i), tbl[i].mosi, tbl[i].nvalid, tbl[i].chan, tbl[i].data);
    end

    // Reset in the middle of the third frame's shift phase.
    do_reset();
    capture(f);
    check_frame(f, "pre1", 16'h0000, 0, 3'd0, 12'h000);
    capture(f);
    check_frame(f, "pre2", 16'h0800, 1, 3'd0, 12'hA5C);
    repeat (40) @(negedge clk);
    check("f3_in_frame", 32'(bus.ss), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_ss", 32'(bus.ss), 32'd1);
    check("midrst_sck", 32'(bus.sck), 32'd1);
    check("midrst_mosi", 32'(bus.mosi), 32'd0);
    check("midrst_valid", 32'(bus.valid_o), 32'd0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.valid_o !== 1'b0 || bus.ss !== 1'b1 || bus.sck !== 1'b1) bad = 1'b1;
    end
    check("midrst_hold", 32'(bad), 32'd0);
    rst = 1'b0;
    capture(f);
    check_frame(f, "post1", 16'h0000, 0, 3'd0, 12'h000);
    capture(f);
    check_frame(f, "post2", 16'h0800, 1, 3'd0, 12'hA5C);

    // miso stuck high, then stuck low.
    mode = 1;
    do_reset();
    capture(f);
    check_frame(f, "ones1", 16'h0000, 0, 3'd0, 12'h000);
    capture(f);
    check_frame(f, "ones2", 16'h0800, 1, 3'd0, 12'hFFF);
    mode = 2;
    do_reset();
    capture(f);
    check_frame(f, "zeros1", 16'h0000, 0, 3'd0, 12'h000);
    capture(f);
    check_frame(f, "zeros2", 16'h0800, 1, 3'd0, 12'h000);

    // Random conversion values against the device-side scoreboard.
    mode = 3;
    do_reset();
    ea = 3'd0;
    for (int i = 0; i < 20; i++) begin
      capture(f);
      e = 15'h0;
      if (i > 0) begin
        check($sformatf("rnd%0d_queue", i), 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end
      check_frame(f, $sformatf("rnd%0d", i), {2'b00, ea, 11'b0}, (i == 0) ? 0 : 1, e[14:12], e[11:0]);
      ea = (ea == 3'(NUM_CH - 1)) ? 3'd0 : ea + 3'd1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
